// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned FSEL_NONE = 0;

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_LOAD_USE,
    HZ_SB_RAW,
    HZ_SB_WAW
  } hz_cause_e;

  // Forward-select width: regfile plus one code per producer stage.
  function automatic int unsigned fsel_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for variable-latency long ops, with
// NPORT pending lookups and a global busy flag.
module hazard_scoreboard #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned LAT_W  = 3,
  parameter int unsigned NPORT  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue,
  input  logic [REG_AW-1:0]       issue_rd,
  input  logic [LAT_W-1:0]        issue_lat,
  input  logic [NPORT*REG_AW-1:0] lookup_reg,
  output logic [NPORT-1:0]        pending,
  output logic                    busy
);

  localparam int unsigned NUM_REGS = 2 ** REG_AW;

  logic [LAT_W-1:0] cnt [NUM_REGS];

  // x0 never holds an entry; a fresh issue overrides any ongoing countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (r == 0)                                  cnt[r] <= '0;
        else if (issue && (issue_rd == REG_AW'(r)))  cnt[r] <= issue_lat;
        else if (cnt[r] != '0)                       cnt[r] <= cnt[r] - LAT_W'(1);
      end
    end
  end

  always_comb begin
    busy    = 1'b0;
    pending = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) busy = busy | (cnt[r] != '0);
    for (int unsigned p = 0; p < NPORT; p++)
      pending[p] = (cnt[lookup_reg[p*REG_AW +: REG_AW]] != '0);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forward selects, load-use / scoreboard stalls,
// branch flush. Optional perf counters via HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NSRC       = 2,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned LAT_W      = 3
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NSRC*REG_AW-1:0]                    rs_ex,
  input  logic [FWD_STAGES-1:0]                     fwd_we,
  input  logic [FWD_STAGES*REG_AW-1:0]              fwd_rd,
  output logic [NSRC*fsel_width(FWD_STAGES)-1:0]    fwd_sel_ex,
  input  logic [NSRC*REG_AW-1:0]                    rs_id,
  input  logic [NSRC-1:0]                           rs_used_id,
  input  logic [REG_AW-1:0]                         rd_id,
  input  logic                                      memtoreg_ex,
  input  logic [REG_AW-1:0]                         rd_ex,
  input  logic                                      lop_id,
  input  logic [LAT_W-1:0]                          lop_lat_id,
  input  logic                                      branch_taken_ex,
  output logic                                      stall_if,
  output logic                                      stall_id,
  output logic                                      flush_ex,
  output logic                                      flush_id,
  output logic                                      sb_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                               perf_stall_cnt,
  output logic [31:0]                               perf_flush_cnt,
  output logic [31:0]                               perf_lop_cnt
`endif
);

  localparam int unsigned FSEL_W = fsel_width(FWD_STAGES);

  logic [NSRC:0]       pending;
  logic                load_use;
  logic                sb_raw;
  logic                sb_waw;
  logic                stall;
  logic                issue;
  logic                found;
  logic [REG_AW-1:0]   rs;
  hz_cause_e           cause;

  // Youngest matching producer wins; x0 always reads the regfile.
  always_comb begin
    fwd_sel_ex = '0;
    found      = 1'b0;
    rs         = '0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      fwd_sel_ex[s*FSEL_W +: FSEL_W] = FSEL_W'(FSEL_NONE);
      found = 1'b0;
      rs    = rs_ex[s*REG_AW +: REG_AW];
      for (int unsigned k = 0; k < FWD_STAGES; k++) begin
        if (!found && fwd_we[k] && (fwd_rd[k*REG_AW +: REG_AW] == rs) && (rs != '0)) begin
          fwd_sel_ex[s*FSEL_W +: FSEL_W] = FSEL_W'(k + 1);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    load_use = 1'b0;
    sb_raw   = 1'b0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (rs_used_id[k] && (rs_id[k*REG_AW +: REG_AW] == rd_ex)) load_use = 1'b1;
      if (rs_used_id[k] && pending[k])                           sb_raw   = 1'b1;
    end
    load_use = load_use & memtoreg_ex & (rd_ex != '0);
    sb_waw   = (rd_id != '0) & pending[NSRC];
    if (load_use)    cause = HZ_LOAD_USE;
    else if (sb_raw) cause = HZ_SB_RAW;
    else if (sb_waw) cause = HZ_SB_WAW;
    else             cause = HZ_NONE;
  end

  // A redirect kills the ID instruction, so it neither stalls nor issues.
  assign stall    = (cause != HZ_NONE) & ~branch_taken_ex;
  assign stall_if = stall;
  assign stall_id = stall;
  assign flush_ex = stall | branch_taken_ex;
  assign flush_id = branch_taken_ex;
  assign issue    = lop_id & ~stall & ~branch_taken_ex & (rd_id != '0);

  hazard_scoreboard #(
    .REG_AW (REG_AW),
    .LAT_W  (LAT_W),
    .NPORT  (NSRC + 1)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (issue),
    .issue_rd   (rd_id),
    .issue_lat  (lop_lat_id),
    .lookup_reg ({rd_id, rs_id}),
    .pending    (pending),
    .busy       (sb_busy)
  );

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_lop_cnt   <= '0;
    end else begin
      if (stall && (perf_stall_cnt != '1))    perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_id && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (issue && (perf_lop_cnt != '1))      perf_lop_cnt   <= perf_lop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed table, multi-cycle scoreboard sequences,
// and random traffic against a behavioural model.
module tb_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int NSRC   = 2;
  localparam int FWD    = 2;
  localparam int LAT_W  = 3;
  localparam int FSEL_W = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NSRC*REG_AW-1:0]   rs_ex;
  logic [FWD-1:0]           fwd_we;
  logic [FWD*REG_AW-1:0]    fwd_rd;
  logic [NSRC*FSEL_W-1:0]   fwd_sel_ex;
  logic [NSRC*REG_AW-1:0]   rs_id;
  logic [NSRC-1:0]          rs_used_id;
  logic [REG_AW-1:0]        rd_id;
  logic                     memtoreg_ex;
  logic [REG_AW-1:0]        rd_ex;
  logic                     lop_id;
  logic [LAT_W-1:0]         lop_lat_id;
  logic                     branch_taken_ex;
  logic                     stall_if, stall_id, flush_ex, flush_id, sb_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]              perf_stall_cnt, perf_flush_cnt, perf_lop_cnt;
`endif

  hazard_ctrl #(
    .REG_AW(REG_AW), .NSRC(NSRC), .FWD_STAGES(FWD), .LAT_W(LAT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rs_ex(rs_ex), .fwd_we(fwd_we), .fwd_rd(fwd_rd),
    .fwd_sel_ex(fwd_sel_ex), .rs_id(rs_id), .rs_used_id(rs_used_id), .rd_id(rd_id),
    .memtoreg_ex(memtoreg_ex), .rd_ex(rd_ex), .lop_id(lop_id), .lop_lat_id(lop_lat_id),
    .branch_taken_ex(branch_taken_ex), .stall_if(stall_if), .stall_id(stall_id),
    .flush_ex(flush_ex), .flush_id(flush_id), .sb_busy(sb_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_lop_cnt(perf_lop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int model_cnt [32];
  int perf_st = 0, perf_fl = 0, perf_lop = 0;
  bit gs;
  int n;

  typedef struct {
    logic [4:0] rs0, rs1;
    logic [1:0] we;
    logic [4:0] rd0, rd1;
    logic       mem;
    logic [4:0] rdx, id0, id1;
    logic [1:0] used;
    logic       br;
    logic [1:0] sel0, sel1;
    logic       st;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic drive_idle();
    rs_ex = '0; fwd_we = '0; fwd_rd = '0; rs_id = '0; rs_used_id = '0; rd_id = '0;
    memtoreg_ex = 1'b0; rd_ex = '0; lop_id = 1'b0; lop_lat_id = '0; branch_taken_ex = 1'b0;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) model_cnt[r] = 0;
    perf_st = 0; perf_fl = 0; perf_lop = 0;
  endtask

  // Compare all outputs with the model, then advance the model across one edge.
  task automatic step(input string name, output bit got_stall);
    logic [3:0] esel_v;
    logic [8:0] exp_v, got_v;
    bit lu, raw, waw, st, br, busy, iss;
    int esel;
    @(negedge clk);
    esel_v = '0;
    for (int s = 0; s < NSRC; s++) begin
      int rs;
      rs = int'(rs_ex[s*REG_AW +: REG_AW]);
      esel = 0;
      for (int k = FWD - 1; k >= 0; k--)
        if (fwd_we[k] && int'(fwd_rd[k*REG_AW +: REG_AW]) == rs && rs != 0) esel = k + 1;
      esel_v[s*2 +: 2] = 2'(esel);
    end
    lu = 0; raw = 0;
    for (int s = 0; s < NSRC; s++) begin
      int r;
      r = int'(rs_id[s*REG_AW +: REG_AW]);
      if (rs_used_id[s]) begin
        if (memtoreg_ex && rd_ex != 0 && r == int'(rd_ex)) lu = 1;
        if (model_cnt[r] > 0) raw = 1;
      end
    end
    waw  = (rd_id != 0) && (model_cnt[rd_id] > 0);
    br   = branch_taken_ex;
    st   = (lu || raw || waw) && !br;
    busy = 0;
    for (int r = 0; r < 32; r++) if (model_cnt[r] > 0) busy = 1;
    iss  = lop_id && !st && !br && rd_id != 0;
    exp_v = {esel_v, st, st, st | br, br, busy};
    got_v = {fwd_sel_ex, stall_if, stall_id, flush_ex, flush_id, sb_busy};
    check(name, 32'(got_v), 32'(exp_v));
    got_stall = stall_id;
    for (int r = 1; r < 32; r++) begin
      if (iss && r == int'(rd_id)) model_cnt[r] = int'(lop_lat_id);
      else if (model_cnt[r] > 0) model_cnt[r]--;
    end
    perf_st += int'(st); perf_fl += int'(br); perf_lop += int'(iss);
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0] = '{5'd5, 5'd0, 2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 2'd1, 2'd0, 1'b0};
    tbl[1] = '{5'd0, 5'd5, 2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[2] = '{5'd6, 5'd6, 2'b10, 5'd6, 5'd6, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 2'd2, 2'd2, 1'b0};
    tbl[3] = '{5'd8, 5'd9, 2'b11, 5'd9, 5'd8, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 2'd2, 2'd1, 1'b0};
    tbl[4] = '{5'd1, 5'd2, 2'b00, 5'd1, 5'd2, 1'b1, 5'd7, 5'd3, 5'd7, 2'b10, 1'b0, 2'd0, 2'd0, 1'b1};
    tbl[5] = '{5'd1, 5'd2, 2'b01, 5'd3, 5'd2, 1'b1, 5'd7, 5'd3, 5'd7, 2'b01, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[6] = '{5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b11, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[7] = '{5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 5'd7, 5'd0, 2'b01, 1'b1, 2'd0, 2'd0, 1'b0};
    tbl[8] = '{5'd7, 5'd7, 2'b01, 5'd7, 5'd7, 1'b0, 5'd7, 5'd7, 5'd7, 2'b11, 1'b0, 2'd1, 2'd1, 1'b0};

    model_clear();
    drive_idle();
    rst_n = 1'b0;
    #3;
    check("reset_outputs", 32'({fwd_sel_ex, stall_if, stall_id, flush_ex, flush_id, sb_busy}), 32'd0);
    #10;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed combinational table with an empty scoreboard.
    foreach (tbl[i]) begin
      drive_idle();
      rs_ex = {tbl[i].rs1, tbl[i].rs0};
      fwd_we = tbl[i].we;
      fwd_rd = {tbl[i].rd1, tbl[i].rd0};
      memtoreg_ex = tbl[i].mem;
      rd_ex = tbl[i].rdx;
      rs_id = {tbl[i].id1, tbl[i].id0};
      rs_used_id = tbl[i].used;
      branch_taken_ex = tbl[i].br;
      #1;
      check($sformatf("table_%0d", i),
            32'({fwd_sel_ex, stall_if, stall_id, flush_ex, flush_id, sb_busy}),
            32'({tbl[i].sel1, tbl[i].sel0, tbl[i].st, tbl[i].st,
                 tbl[i].st | tbl[i].br, tbl[i].br, 1'b0}));
      step("table_model", gs);
    end

    // Long op lat 4 to x9, then a reader of x9 stalls exactly 4 cycles.
    drive_idle(); lop_id = 1'b1; rd_id = 5'd9; lop_lat_id = 3'd4;
    step("raw_issue", gs);
    drive_idle(); rs_id = {5'd0, 5'd9}; rs_used_id = 2'b01;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      step("raw_wait", gs);
      if (gs) n++; else break;
    end
    check("raw_stall_len", 32'(n), 32'd4);

    // WAW: pending x3 (lat 3) blocks a second long op to x3 until drained.
    drive_idle(); lop_id = 1'b1; rd_id = 5'd3; lop_lat_id = 3'd3;
    step("waw_issue", gs);
    lop_lat_id = 3'd5;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      step("waw_wait", gs);
      if (gs) n++; else break;
    end
    check("waw_stall_len", 32'(n), 32'd3);
    drive_idle(); #1;
    check("waw_reissue_busy", 32'(sb_busy), 32'd1);
    for (int c = 0; c < 6; c++) step("drain", gs);

    // Load-use coinciding with a taken branch: flush only, no issue.
    drive_idle(); memtoreg_ex = 1'b1; rd_ex = 5'd7; rs_id = {5'd7, 5'd0}; rs_used_id = 2'b10;
    branch_taken_ex = 1'b1; lop_id = 1'b1; rd_id = 5'd4; lop_lat_id = 3'd2;
    #1;
    check("branch_vs_loaduse", 32'({stall_if, stall_id, flush_ex, flush_id, sb_busy}), 32'b00110);
    step("branch_model", gs);
    drive_idle(); #1;
    check("branch_no_issue", 32'(sb_busy), 32'd0);
    step("branch_after", gs);

    // Async reset in the middle of a pending long op.
    drive_idle(); lop_id = 1'b1; rd_id = 5'd9; lop_lat_id = 3'd2;
    step("rst_issue", gs);
    drive_idle(); rs_id = {5'd0, 5'd9}; rs_used_id = 2'b01;
    #1 rst_n = 1'b0;
    #1;
    check("rst_clears", 32'({stall_if, stall_id, flush_ex, flush_id, sb_busy}), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("rst_perf", perf_stall_cnt | perf_flush_cnt | perf_lop_cnt, 32'd0);
`endif
    model_clear();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    step("rst_x9_read", gs);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      rs_ex = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_we = 2'($urandom_range(0, 3));
      fwd_rd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rs_id = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rs_used_id = 2'($urandom_range(0, 3));
      rd_id = 5'($urandom_range(0, 7));
      memtoreg_ex = ($urandom_range(0, 2) == 0);
      rd_ex = 5'($urandom_range(0, 7));
      lop_id = ($urandom_range(0, 3) == 0);
      lop_lat_id = 3'($urandom_range(0, 7));
      branch_taken_ex = ($urandom_range(0, 7) == 0);
      step("random", gs);
    end

`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall", perf_stall_cnt, 32'(perf_st));
    check("perf_flush", perf_flush_cnt, 32'(perf_fl));
    check("perf_lop",   perf_lop_cnt,   32'(perf_lop));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
